// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first.
// Results are loaded together on the last bit and held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             c;
  logic             sa;
  logic             sb;

  logic x;
  logic y;
  logic dbit;
  logic nb;
  logic last;

  always_comb begin
    x    = ra[0];
    y    = rb[0];
    dbit = x ^ y ^ c;
    nb   = (~x & y) | (~(x ^ y) & c);
    last = (cnt == CW'(WIDTH - 1));
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      c     <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= bin;
            sa    <= a[WIDTH-1];
            sb    <= b[WIDTH-1];
            rd    <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          ra <= ra >> 1;
          rb <= rb >> 1;
          c  <= nb;
          rd <= {dbit, rd[WIDTH-1:1]};
          // the final bit's dbit is the result MSB, so ovf uses it directly
          if (last) begin
            diff  <= {dbit, rd[WIDTH-1:1]};
            bout  <= nb;
            ovf   <= (sa != sb) && (dbit != sa);
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_diff;
  int pulses;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tb,
                    input logic tbin, input logic [7:0] ed,
                    input logic eb, input logic eo, input bit glitch);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55; bin = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      chk("busy_shift", busy, 1);
      chk("done_early", done, 0);
      chk("diff_hold", diff, last_diff);
      if (done) pulses++;
      if (glitch && i == 3) begin
        start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
    chk("ovf", ovf, eo);
    if (done) pulses++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_after", done, 0);
      chk("diff_after", diff, ed);
      if (done) pulses++;
    end
    chk("pulse_count", pulses, 1);
    last_diff = ed;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_diff = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);

    // reset lands on edge k+4 of a running subtraction
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_diff", diff, 8'h00);
    chk("abort_done", done, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("abort_pulses", pulses, 0);
    last_diff = 8'h00;
    op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2 to 64.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit, a request to begin a subtraction.
REQ-005 The module SHALL have port a, input, WIDTH bits, the minuend, sampled only when start is accepted.
REQ-006 The module SHALL have port b, input, WIDTH bits, the subtrahend, sampled only when start is accepted.
REQ-007 The module SHALL have port bin, input, 1 bit, the borrow-in for the LSB, sampled only when start is accepted.
REQ-008 The module SHALL have port diff, output, WIDTH bits, the registered result a - b - bin modulo 2^WIDTH.
REQ-009 The module SHALL have port bout, output, 1 bit, the registered borrow-out from the MSB.
REQ-010 The module SHALL have port ovf, output, 1 bit, registered two's-complement signed overflow.
REQ-011 The module SHALL have port busy, output, 1 bit, high while a subtraction is in progress.
REQ-012 The module SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted at edge k: capture a, b and bin into internal registers, clear the bit counter, and enter SHIFT.
REQ-015 busy SHALL be 1 exactly while the state is SHIFT; start SHALL be ignored while busy=1, and the captured operands SHALL be unaffected.
REQ-016 Each SHIFT cycle SHALL process one bit, LSB first, with x = minuend bit, y = subtrahend bit, c = borrow register.
REQ-017 The difference bit for each cycle SHALL be x^y^c.
REQ-018 The next borrow for each cycle SHALL be (~x&y) | (~(x^y)&c).
REQ-019 Bit i SHALL be processed at edge k+1+i; the final bit SHALL be processed at edge k+WIDTH.
REQ-020 At edge k+WIDTH the module SHALL load diff, bout and ovf simultaneously, set done=1, and enter DONE.
REQ-021 Latency SHALL therefore be exactly WIDTH cycles from the start-accept edge to the first cycle in which done=1 is visible.
REQ-022 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the captured operands; bin SHALL NOT affect the overflow rule except through diff.
REQ-023 diff, bout and ovf SHALL hold their last values from completion until the next completion; they SHALL NOT change during SHIFT.
REQ-024 DONE SHALL last exactly one cycle.
REQ-025 From DONE, start=0 SHALL go to IDLE and start=1 SHALL go to SHIFT, giving back-to-back operations with one done pulse per operation.
REQ-026 done SHALL be 0 in every state other than DONE.
REQ-027 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-028 When rst=1 at a rising edge, the module SHALL set the state to IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, and clear the borrow register, counter and operand registers.
REQ-029 rst SHALL take priority over start in the same cycle.
REQ-030 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-031 The first start after reset deasserts SHALL be accepted normally.

Verification (WIDTH=8; k is the start-accept edge)
REQ-032 The bench SHALL drive a=0x05, b=0x03, bin=0 and require busy=1 for 8 cycles, done=1 only after edge k+8, diff=0x02, bout=0, ovf=0.
REQ-033 The bench SHALL drive a=0x03, b=0x05, bin=0 and require diff=0xFE, bout=1, ovf=0.
REQ-034 The bench SHALL drive a=0x80, b=0x01, bin=0 and require diff=0x7F, bout=0, ovf=1.
REQ-035 The bench SHALL drive a=0x00, b=0x00, bin=1 and require diff=0xFF, bout=1, ovf=0.
REQ-036 The bench SHALL pulse start with a=0x10, b=0x01 at cycle k+3 of a 0x05-0x03 run and require that it is ignored, the result is 0x02, and exactly one done pulse occurs.
REQ-037 The bench SHALL assert rst at cycle k+4 and require busy=0 and diff=0 on the next cycle with no done pulse, then a new start with a=0x09, b=0x04 to give diff=0x05.
